// File: rtl/ip_dram_bridge.sv
// cZ80 8-bit bus to ip_sdram 128-bit line bridge: paged 16 KB window, one-line read buffer, posted writes.
// Optional hit counter on PAGE_PORT+1 when DRAM_BRIDGE_HIT_COUNTER_EN is defined.
module ip_dram_bridge #(
    parameter logic [1:0] WINDOW_BASE = 2'b10,
    parameter logic [7:0] PAGE_PORT   = 8'h20,
    parameter logic [5:0] DRAM_BASE   = 6'd0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sdram_init_busy,
    input  logic [15:0]  bus_address,
    input  logic         bus_memreq,
    input  logic         bus_ioreq,
    input  logic         bus_valid,
    output logic         bus_ready,
    input  logic         bus_write,
    input  logic [7:0]   bus_wdata,
    output logic [7:0]   bus_rdata,
    output logic         bus_rdata_en,
    output logic [26:0]  dram_address,
    output logic         dram_write,
    output logic         dram_valid,
    input  logic         dram_ready,
    output logic [127:0] dram_wdata,
    output logic [15:0]  dram_wdata_mask,
    input  logic [127:0] dram_rdata,
    input  logic         dram_rdata_en
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

    state_t         state;
    state_t         state_nxt;

    logic [7:0]     page;
    logic           line_valid;
    logic [17:0]    line_tag;
    logic [127:0]   line_data;
    logic [3:0]     byte_sel;
    logic [7:0]     wdata_q;
    logic [7:0]     resp_q;

    logic           sel_mem;
    logic           sel_io;
    logic           sel_cnt;
    logic           accept;
    logic           hit;
    logic           line_fill;
    logic [17:0]    req_tag;
    logic [3:0]     req_k;

    assign sel_mem = bus_memreq && (bus_address[15:14] == WINDOW_BASE);
    assign sel_io  = bus_ioreq && !bus_memreq && (bus_address[7:0] == PAGE_PORT);

`ifdef DRAM_BRIDGE_HIT_COUNTER_EN
    logic [7:0]     hit_cnt;
    assign sel_cnt = bus_ioreq && !bus_memreq && (bus_address[7:0] == PAGE_PORT + 8'd1);
`else
    assign sel_cnt = 1'b0;
`endif

    // Ready is forced low during reset so the OR-bus sees all outputs at 0.
    assign bus_ready = !reset && (state == IDLE) && !sdram_init_busy && (sel_mem || sel_io || sel_cnt);
    assign accept    = bus_valid && bus_ready;
    assign req_tag   = {page, bus_address[13:4]};
    assign req_k     = bus_address[3:0];
    assign hit       = line_valid && (line_tag == req_tag);
    assign line_fill = (state == RD_WAIT) && dram_rdata_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_mem) begin
                        if (bus_write)  state_nxt = WR_REQ;
                        else if (hit)   state_nxt = RESP;
                        else            state_nxt = RD_REQ;
                    end else if (!bus_write) begin
                        state_nxt = RESP;
                    end
                end
            end
            RD_REQ:  if (dram_ready)    state_nxt = RD_WAIT;
            RD_WAIT: if (dram_rdata_en) state_nxt = RESP;
            WR_REQ:  if (dram_ready)    state_nxt = IDLE;
            RESP:                       state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus_rdata_en    = (state == RESP);
        bus_rdata       = (state == RESP) ? resp_q : 8'h00;
        dram_valid      = (state == RD_REQ) || (state == WR_REQ);
        dram_write      = (state == WR_REQ);
        dram_wdata      = (state == WR_REQ) ? {16{wdata_q}} : 128'h0;
        dram_wdata_mask = (state == WR_REQ) ? ~(16'h0001 << byte_sel) : 16'h0000;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page         <= 8'h00;
            line_valid   <= 1'b0;
            line_tag     <= 18'h0;
            dram_address <= 27'h0;
            byte_sel     <= 4'h0;
            wdata_q      <= 8'h00;
            resp_q       <= 8'h00;
        end else begin
            if (accept) begin
                if (sel_mem) begin
                    dram_address <= {DRAM_BASE, page, bus_address[13:4], 3'b000};
                    byte_sel     <= req_k;
                    wdata_q      <= bus_wdata;
                    if (!bus_write) resp_q <= line_data[{req_k, 3'b000} +: 8];
                end else if (sel_io) begin
                    if (bus_write) page   <= bus_wdata;
                    else           resp_q <= page;
                end
`ifdef DRAM_BRIDGE_HIT_COUNTER_EN
                else if (sel_cnt && !bus_write) begin
                    resp_q <= hit_cnt;
                end
`endif
            end
            if (line_fill) begin
                line_valid <= 1'b1;
                line_tag   <= dram_address[20:3];
                resp_q     <= dram_rdata[{byte_sel, 3'b000} +: 8];
            end
        end
    end

    // NOTE: line data needs no reset; line_valid guards every use of it.
    always_ff @(posedge clk) begin
        if (line_fill)
            line_data <= dram_rdata;
        else if (accept && sel_mem && bus_write && hit)
            line_data[{req_k, 3'b000} +: 8] <= bus_wdata;
    end

`ifdef DRAM_BRIDGE_HIT_COUNTER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hit_cnt <= 8'h00;
        else if (accept && sel_cnt && bus_write)
            hit_cnt <= 8'h00;
        else if (accept && sel_mem && !bus_write && hit && (hit_cnt != 8'hFF))
            hit_cnt <= hit_cnt + 8'd1;
    end
`endif

endmodule
